// File: rtl/img_processor.sv
// Per-pixel point-operation engine for 8-bit grayscale streams.
// Brighten, darken, threshold or invert selected by s; one registered
// result per clock, latency of one cycle, synchronous active-high reset.
module img_processor (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ip,
  input  logic [7:0] value,
  input  logic [7:0] threshold,
  input  logic [1:0] s,
  output logic [7:0] op
);

  typedef enum logic [1:0] {
    MODE_BRIGHTEN = 2'b00,
    MODE_DARKEN   = 2'b01,
    MODE_THRESH   = 2'b10,
    MODE_INVERT   = 2'b11
  } mode_e;

  mode_e      mode;
  logic [8:0] sum;
  logic [8:0] diff;
  logic [7:0] op_d;
  logic [7:0] op_q;

  assign mode = mode_e'(s);

  // 9-bit add/subtract: bit 8 is the carry (brighten) or borrow (darken)
  always_comb begin
    sum  = {1'b0, ip} + {1'b0, value};
    diff = {1'b0, ip} - {1'b0, value};
  end

  // Select the point operation for the pixel sampled this cycle
  always_comb begin
    op_d = '0;
    unique case (mode)
      MODE_BRIGHTEN: op_d = sum[8]  ? '1 : sum[7:0];
      MODE_DARKEN:   op_d = diff[8] ? '0 : diff[7:0];
      MODE_THRESH:   op_d = (ip >= threshold) ? '1 : '0;
      MODE_INVERT:   op_d = ~ip;
    endcase
  end

  // Output register; reset discards the pixel presented that cycle
  always_ff @(posedge clk) begin
    if (rst) op_q <= '0;
    else     op_q <= op_d;
  end

  assign op = op_q;

endmodule

// File: tb/tb_img_processor.sv
// Self-checking bench for img_processor: directed vector table plus
// reset, mode-switching and streaming sequences.
module tb_img_processor;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ip;
  logic [7:0] value;
  logic [7:0] threshold;
  logic [1:0] s;
  logic [7:0] op;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0] s;
    logic [7:0] ip;
    logic [7:0] value;
    logic [7:0] threshold;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[22];

  img_processor dut (
    .clk       (clk),
    .rst       (rst),
    .ip        (ip),
    .value     (value),
    .threshold (threshold),
    .s         (s),
    .op        (op)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%02h) expected %0d (0x%02h)", name, act, act, exp, exp);
    end
  endtask

  // Drive inputs away from the edge, clock once, sample just after the edge
  task automatic apply(input logic r, input logic [1:0] sv, input logic [7:0] pix,
                       input logic [7:0] val, input logic [7:0] th);
    @(negedge clk);
    rst = r; s = sv; ip = pix; value = val; threshold = th;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [1:0] sv, input logic [7:0] pix,
                              input logic [7:0] val, input logic [7:0] th,
                              input logic [7:0] e);
    vec_t v;
    v.s = sv; v.ip = pix; v.value = val; v.threshold = th; v.exp = e;
    return v;
  endfunction

  initial begin
    // brighten
    vecs[0]  = mk(2'b00, 8'd100, 8'd60, 8'd160, 8'd160);
    vecs[1]  = mk(2'b00, 8'd195, 8'd60, 8'd160, 8'd255);
    vecs[2]  = mk(2'b00, 8'd196, 8'd60, 8'd160, 8'd255);
    vecs[3]  = mk(2'b00, 8'd255, 8'd0,  8'd160, 8'd255);
    vecs[4]  = mk(2'b00, 8'd77,  8'd0,  8'd160, 8'd77);
    vecs[5]  = mk(2'b00, 8'd255, 8'd1,  8'd160, 8'd255);
    vecs[6]  = mk(2'b00, 8'd0,   8'd255,8'd160, 8'd255);
    // darken
    vecs[7]  = mk(2'b01, 8'd100, 8'd60, 8'd160, 8'd40);
    vecs[8]  = mk(2'b01, 8'd60,  8'd60, 8'd160, 8'd0);
    vecs[9]  = mk(2'b01, 8'd30,  8'd60, 8'd160, 8'd0);
    vecs[10] = mk(2'b01, 8'd0,   8'd0,  8'd160, 8'd0);
    vecs[11] = mk(2'b01, 8'd77,  8'd0,  8'd160, 8'd77);
    vecs[12] = mk(2'b01, 8'd255, 8'd1,  8'd160, 8'd254);
    // threshold (value deliberately non-zero and ignored)
    vecs[13] = mk(2'b10, 8'd160, 8'd60, 8'd160, 8'd255);
    vecs[14] = mk(2'b10, 8'd159, 8'd60, 8'd160, 8'd0);
    vecs[15] = mk(2'b10, 8'd255, 8'd60, 8'd160, 8'd255);
    vecs[16] = mk(2'b10, 8'd0,   8'd60, 8'd0,   8'd255);
    vecs[17] = mk(2'b10, 8'd254, 8'd60, 8'd255, 8'd0);
    // invert
    vecs[18] = mk(2'b11, 8'h3C,  8'd60, 8'd160, 8'hC3);
    vecs[19] = mk(2'b11, 8'h00,  8'd60, 8'd160, 8'hFF);
    vecs[20] = mk(2'b11, 8'hFF,  8'd60, 8'd160, 8'h00);
    vecs[21] = mk(2'b11, 8'hA5,  8'd60, 8'd160, 8'h5A);

    rst = 1'b1; s = 2'b00; ip = 8'hAA; value = 8'd0; threshold = 8'd0;

    // Reset held for two edges with a live pixel on the input
    apply(1'b1, 2'b00, 8'hAA, 8'd0, 8'd0);
    check("reset_edge1", op, 8'h00);
    apply(1'b1, 2'b00, 8'hAA, 8'd0, 8'd0);
    check("reset_edge2", op, 8'h00);
    apply(1'b0, 2'b00, 8'd10, 8'd5, 8'd0);
    check("first_after_reset", op, 8'd15);
    // Output holds until the next edge
    #3;
    check("hold_between_edges", op, 8'd15);

    // Directed table
    for (int i = 0; i < 22; i++) begin
      apply(1'b0, vecs[i].s, vecs[i].ip, vecs[i].value, vecs[i].threshold);
      check($sformatf("vec%0d", i), op, vecs[i].exp);
    end

    // Mode switched every cycle with fixed operands
    apply(1'b0, 2'b00, 8'd100, 8'd60, 8'd160);
    check("switch_s00", op, 8'd160);
    apply(1'b0, 2'b01, 8'd100, 8'd60, 8'd160);
    check("switch_s01", op, 8'd40);
    apply(1'b0, 2'b10, 8'd100, 8'd60, 8'd160);
    check("switch_s10", op, 8'd0);
    apply(1'b0, 2'b11, 8'd100, 8'd60, 8'd160);
    check("switch_s11", op, 8'd155);

    // Darken stream with a mid-stream reset at pixel 500
    begin
      logic [7:0] pix;
      logic [7:0] exp;
      for (int i = 0; i < 1000; i++) begin
        pix = 8'((i * 37 + 11) % 256);
        exp = (pix > 8'd60) ? pix - 8'd60 : 8'd0;
        if (i == 500) begin
          apply(1'b1, 2'b01, pix, 8'd60, 8'd0);
          check("stream_reset", op, 8'd0);
        end else begin
          apply(1'b0, 2'b01, pix, 8'd60, 8'd0);
          check($sformatf("stream%0d", i), op, exp);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
